// File: rtl/demux_n_stream_if.sv
// Handshake bundle between a single-stream producer and the N-way demux; define
// DEMUX_DROP_CNT_EN to carry the 8-bit drop_cnt status alongside err.
interface demux_n_stream_if #(
    parameter int DATA_SIZE = 32,
    parameter int NUM_OUT   = 4,
    parameter int SEL_W     = 2
);
    logic [SEL_W-1:0]             sel;
    logic                         in_valid;
    logic                         in_ready;
    logic [DATA_SIZE-1:0]         din;
    logic [NUM_OUT-1:0]           out_valid;
    logic [NUM_OUT-1:0]           out_ready;
    logic [NUM_OUT*DATA_SIZE-1:0] dout;
    logic                         err;
    logic                         err_clr;
`ifdef DEMUX_DROP_CNT_EN
    logic [7:0]                   drop_cnt;

    modport master (
        output sel, in_valid, din, out_ready, err_clr,
        input  in_ready, out_valid, dout, err, drop_cnt
    );

    modport slave (
        input  sel, in_valid, din, out_ready, err_clr,
        output in_ready, out_valid, dout, err, drop_cnt
    );
`else
    modport master (
        output sel, in_valid, din, out_ready, err_clr,
        input  in_ready, out_valid, dout, err
    );

    modport slave (
        input  sel, in_valid, din, out_ready, err_clr,
        output in_ready, out_valid, dout, err
    );
`endif
endinterface

// File: rtl/demux_n_stream.sv
// Routes one valid/ready word stream to NUM_OUT single-entry channels, 1-cycle latency;
// in_ready drops only when the addressed channel is full and not draining. DEMUX_DROP_CNT_EN adds drop_cnt.
module demux_n_stream #(
    parameter int DATA_SIZE = 32,
    parameter int NUM_OUT   = 4,
    parameter int SEL_W     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    demux_n_stream_if.slave   bus
);

    logic [NUM_OUT-1:0]   vld_q;
    logic [DATA_SIZE-1:0] data_q [NUM_OUT];
    logic                 err_q;

    logic [NUM_OUT-1:0]   hit;
    logic [NUM_OUT-1:0]   load;
    logic                 in_range;
    logic                 room;
    logic                 in_ready_c;
    logic                 xfer;
    logic                 drop;

    // Decode sel against real channels only, so an out-of-range sel never indexes state.
    always_comb begin
        hit  = '0;
        room = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) begin
            hit[k] = (bus.sel == SEL_W'(k));
            if (hit[k]) begin
                room = ~vld_q[k] | bus.out_ready[k];
            end
        end
        in_range   = |hit;
        in_ready_c = ~in_range | room;
    end

    assign xfer = bus.in_valid & in_ready_c;
    assign load = hit & {NUM_OUT{xfer}};
    assign drop = xfer & ~in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            err_q <= 1'b0;
            for (int k = 0; k < NUM_OUT; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                // A new word into a draining channel keeps it valid: full throughput.
                if (load[k]) begin
                    data_q[k] <= bus.din;
                    vld_q[k]  <= 1'b1;
                end else if (bus.out_ready[k]) begin
                    vld_q[k]  <= 1'b0;
                end
            end
            if (drop) begin
                err_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

`ifdef DEMUX_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 8'd0;
        end else if (drop) begin
            if (bus.err_clr) begin
                drop_cnt_q <= 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end else if (bus.err_clr) begin
            drop_cnt_q <= 8'd0;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif

    genvar g;
    generate
        for (g = 0; g < NUM_OUT; g++) begin : g_out
            assign bus.dout[g*DATA_SIZE +: DATA_SIZE] = vld_q[g] ? data_q[g] : '0;
        end
    endgenerate

    assign bus.out_valid = vld_q;
    assign bus.in_ready  = in_ready_c;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_demux_n_stream.sv
// Directed bench: 4-channel and 3-channel instances exercised against hand-computed vectors.
module tb_demux_n_stream;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    demux_n_stream_if #(.DATA_SIZE(32), .NUM_OUT(4), .SEL_W(2)) bus4 ();
    demux_n_stream_if #(.DATA_SIZE(32), .NUM_OUT(3), .SEL_W(2)) bus3 ();

    demux_n_stream #(.DATA_SIZE(32), .NUM_OUT(4), .SEL_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    demux_n_stream #(.DATA_SIZE(32), .NUM_OUT(3), .SEL_W(2)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus4.sel = '0; bus4.in_valid = 1'b0; bus4.din = '0; bus4.out_ready = '0; bus4.err_clr = 1'b0;
        bus3.sel = '0; bus3.in_valid = 1'b0; bus3.din = '0; bus3.out_ready = '0; bus3.err_clr = 1'b0;
        #2;
        chk("rst_out_valid", 128'(bus4.out_valid), 128'(4'b0000));
        chk("rst_dout",      128'(bus4.dout),      128'(0));
        chk("rst_err",       128'(bus4.err),       128'(0));
        chk("rst_in_ready",  128'(bus4.in_ready),  128'(1));
        tick();
        tick();
        rst_n = 1'b1;

        // Single word to channel 2
        bus4.sel = 2'd2; bus4.din = 32'hA5A5_A5A5; bus4.in_valid = 1'b1;
        #1 chk("ch2_in_ready", 128'(bus4.in_ready), 128'(1));
        tick();
        bus4.in_valid = 1'b0;
        chk("ch2_out_valid", 128'(bus4.out_valid), 128'(4'b0100));
        chk("ch2_dout",      128'(bus4.dout),      {32'h0, 32'hA5A5_A5A5, 64'h0});
        bus4.out_ready = 4'hF;
        tick();
        chk("ch2_drained", 128'(bus4.out_valid), 128'(4'b0000));
        chk("ch2_dout_zero", 128'(bus4.dout), 128'(0));
        bus4.out_ready = 4'h0;

        // Backpressure on channel 1
        bus4.sel = 2'd1; bus4.din = 32'h0000_0011; bus4.in_valid = 1'b1;
        tick();
        bus4.din = 32'h0000_0022;
        #1 chk("bp_in_ready_low", 128'(bus4.in_ready), 128'(0));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_dout1", 128'(bus4.dout[63:32]), 128'(32'h11));
            chk("bp_hold_valid", 128'(bus4.out_valid),   128'(4'b0010));
        end
        bus4.out_ready = 4'b0010;
        #1 chk("bp_in_ready_high", 128'(bus4.in_ready), 128'(1));
        tick();
        bus4.in_valid = 1'b0;
        chk("bp_new_word",  128'(bus4.dout[63:32]), 128'(32'h22));
        chk("bp_new_valid", 128'(bus4.out_valid),   128'(4'b0010));
        tick();
        chk("bp_drained", 128'(bus4.out_valid), 128'(4'b0000));
        bus4.out_ready = 4'h0;

        // Back-to-back stream to channel 3
        bus4.out_ready = 4'b1000;
        bus4.sel = 2'd3; bus4.in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus4.din = 32'(i);
            tick();
            chk("b2b_valid", 128'(bus4.out_valid), 128'(4'b1000));
            chk("b2b_dout",  128'(bus4.dout),      {32'(i), 96'h0});
        end
        bus4.in_valid = 1'b0;
        tick();
        chk("b2b_end", 128'(bus4.out_valid), 128'(4'b0000));
        bus4.out_ready = 4'h0;

        // Out-of-range select on the 3-channel instance
        bus3.sel = 2'd3; bus3.din = 32'hDEAD_BEEF; bus3.in_valid = 1'b1;
        #1 chk("oor_in_ready", 128'(bus3.in_ready), 128'(1));
        tick();
        bus3.in_valid = 1'b0;
        chk("oor_no_valid", 128'(bus3.out_valid), 128'(3'b000));
        chk("oor_dout",     128'(bus3.dout),      128'(0));
        chk("oor_err_set",  128'(bus3.err),       128'(1));
`ifdef DEMUX_DROP_CNT_EN
        chk("oor_drop_1", 128'(bus3.drop_cnt), 128'(1));
`endif
        bus3.err_clr = 1'b1;
        tick();
        bus3.err_clr = 1'b0;
        chk("oor_err_clr", 128'(bus3.err), 128'(0));
`ifdef DEMUX_DROP_CNT_EN
        chk("oor_drop_0", 128'(bus3.drop_cnt), 128'(0));
        bus3.in_valid = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        bus3.in_valid = 1'b0;
        chk("oor_drop_sat", 128'(bus3.drop_cnt), 128'(255));
`endif
        bus3.in_valid = 1'b1; bus3.err_clr = 1'b1;
        tick();
        bus3.in_valid = 1'b0; bus3.err_clr = 1'b0;
        chk("oor_set_wins", 128'(bus3.err), 128'(1));
`ifdef DEMUX_DROP_CNT_EN
        chk("oor_inc_wins", 128'(bus3.drop_cnt), 128'(1));
`endif
        bus3.sel = 2'd0; bus3.din = 32'h77; bus3.in_valid = 1'b0;
        tick();
        chk("idle_ignored", 128'(bus3.out_valid), 128'(3'b000));

        // Mid-cycle asynchronous reset with channels 0 and 2 full
        bus4.sel = 2'd0; bus4.din = 32'hC0; bus4.in_valid = 1'b1;
        tick();
        bus4.sel = 2'd2; bus4.din = 32'hC2;
        tick();
        bus4.in_valid = 1'b0;
        chk("pre_rst_valid", 128'(bus4.out_valid), 128'(4'b0101));
        chk("pre_rst_dout",  128'(bus4.dout),      {32'h0, 32'hC2, 32'h0, 32'hC0});
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid",    128'(bus4.out_valid), 128'(4'b0000));
        chk("arst_dout",     128'(bus4.dout),      128'(0));
        chk("arst_err3",     128'(bus3.err),       128'(0));
        chk("arst_in_ready", 128'(bus4.in_ready),  128'(1));
        tick();
        rst_n = 1'b1;
        bus4.sel = 2'd0; bus4.din = 32'h5; bus4.in_valid = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
        chk("post_rst_valid", 128'(bus4.out_valid), 128'(4'b0001));
        chk("post_rst_dout",  128'(bus4.dout),      128'(32'h5));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_n_stream.md
DEMUX_N_STREAM -- requirements
Module: demux_n_stream

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, width of each data word.
REQ-002 SHALL have parameter NUM_OUT, default 4, number of output channels, legal range 2..16.
REQ-003 SHALL have parameter SEL_W, default 2, width of sel; SEL_W >= clog2(NUM_OUT).
REQ-004 SHALL use one clock; reset is asynchronous and active-low: clk input 1 rising-edge clock; rst_n input 1 asynchronous active-low reset.
REQ-005 SHALL have port sel, input, SEL_W bits: destination channel, sampled with din.
REQ-006 SHALL have port in_valid, input, 1 bit: din/sel valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts din/sel this cycle.
REQ-008 SHALL have port din, input, DATA_SIZE bits: input word.
REQ-009 SHALL have port out_valid, output, NUM_OUT bits: per-channel word valid.
REQ-010 SHALL have port out_ready, input, NUM_OUT bits: per-channel consumer ready.
REQ-011 SHALL have port dout, output, NUM_OUT*DATA_SIZE bits: channel k at bits [k*DATA_SIZE +: DATA_SIZE].
REQ-012 SHALL have port err, output, 1 bit: sticky out-of-range-select flag.
REQ-013 SHALL have port err_clr, input, 1 bit: synchronous clear of err.

Function
REQ-014 SHALL hold one registered entry per channel (data + valid); an input transfer occurs when in_valid & in_ready at a rising clk edge.
REQ-015 SHALL drive in_ready = 1 when sel >= NUM_OUT, else in_ready = ~out_valid[sel] | out_ready[sel] (combinational, no dependency on in_valid).
REQ-016 SHALL load din into channel sel and set out_valid[sel] on a transfer; latency exactly 1 cycle from transfer to out_valid.
REQ-017 SHALL clear out_valid[k] on out_valid[k] & out_ready[k] unless a new transfer targets k in the same cycle, in which case out_valid[k] stays 1 and dout[k] takes the new word (full throughput, one word per cycle per channel).
REQ-018 SHALL hold dout[k] stable while out_valid[k]=1 and out_ready[k]=0.
REQ-019 SHALL drive dout[k] to all zeros whenever out_valid[k]=0.
REQ-020 SHALL leave channels not addressed by sel unchanged by a transfer.
REQ-021 SHALL, on a transfer with sel >= NUM_OUT, discard din, change no channel, and set err at the same edge.
REQ-022 SHALL clear err on err_clr=1; if err_clr and an out-of-range transfer coincide, err SHALL end the cycle set (set wins).
REQ-023 SHALL ignore sel and din when in_valid=0.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear out_valid to 0, dout to 0, err to 0 and any drop counter to 0, independent of clk.
REQ-025 SHALL discard any held words on reset mid-operation; first transfer after rst_n deassertion behaves as from an empty state.
REQ-026 SHALL drive in_ready per REQ-015 during reset (all channels empty, so 1).

Configuration
REQ-027 SHALL, when DEMUX_DROP_CNT_EN is defined, add output port drop_cnt (8 bits) counting out-of-range transfers, saturating at 255, cleared by err_clr (increment wins if coincident, giving 1).
REQ-028 SHALL, when DEMUX_DROP_CNT_EN is undefined, omit port drop_cnt and its logic; all other behaviour identical.

Verification
REQ-029 SHALL cover: reset, then din=0xA5A5A5A5 sel=2 in_valid=1 one cycle -> next cycle out_valid=4'b0100, dout[2]=0xA5A5A5A5, all other dout 0.
REQ-030 SHALL cover: channel 1 full, out_ready[1]=0, sel=1 in_valid=1 -> in_ready=0, dout[1] unchanged for 5 cycles; raise out_ready[1] -> in_ready=1 and new word appears next cycle.
REQ-031 SHALL cover: back-to-back words 1,2,3 to sel=3 with out_ready[3]=1 -> out_valid[3] high 3 consecutive cycles, dout[3]=1,2,3.
REQ-032 SHALL cover: NUM_OUT=3, sel=3 in_valid=1 -> in_ready=1, no out_valid change, err=1 next cycle; err_clr=1 -> err=0 (with DEMUX_DROP_CNT_EN: drop_cnt 1 then 0).
REQ-033 SHALL cover: channels 0 and 2 full, assert rst_n=0 between clk edges -> out_valid=0 and dout=0 immediately, err=0.
REQ-034 SHALL cover: with DEMUX_DROP_CNT_EN, 300 out-of-range transfers -> drop_cnt=255.
